statistics_counter_bank: RTL and testbench

//  Parametrised bank of N_COUNTERS packet/byte counters in block RAM, one clock domain.

---
 rtl/statistics_counter_bank.sv | 163 ++++++++++++++++
 tb/tb_statistics_counter_bank.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/statistics_counter_bank.sv
// Bank of packet/byte counters held in inferred block RAM, updated through a
// three-stage read-modify-write pipeline with same-address forwarding.
module statistics_counter_bank #(
  parameter int N_COUNTERS = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 32,
  parameter int INC_WIDTH  = 16,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inc_valid,
  output logic                  inc_ready,
  input  logic [ADDR_WIDTH-1:0] inc_addr,
  input  logic [INC_WIDTH-1:0]  inc_din,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_clear,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  ovf,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH:0] LP_N = (ADDR_WIDTH+1)'(N_COUNTERS);

  logic [CNT_WIDTH-1:0]  r_mem [N_COUNTERS];
  logic [CNT_WIDTH-1:0]  r_ram_q;

  logic [ADDR_WIDTH:0]   r_init_cnt;
  logic                  r_init_done;

  logic                  r_s0_valid, r_s0_rd, r_s0_clr, r_s0_inr;
  logic [ADDR_WIDTH-1:0] r_s0_addr;
  logic [INC_WIDTH-1:0]  r_s0_din;

  logic                  r_s1_valid, r_s1_rd, r_s1_clr, r_s1_inr;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic [INC_WIDTH-1:0]  r_s1_din;

  logic                  r_fwd;
  logic [CNT_WIDTH-1:0]  r_fwd_data;

  logic                  r_rd_valid;
  logic [CNT_WIDTH-1:0]  r_rd_data;
  logic                  r_ovf;

  logic                  w_rd_acc, w_inc_acc;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [CNT_WIDTH-1:0]  w_old;
  logic [CNT_WIDTH:0]    w_sum;
  logic                  w_carry;
  logic [CNT_WIDTH-1:0]  w_inc_val;
  logic                  w_s2_we;
  logic [CNT_WIDTH-1:0]  w_s2_wdata;
  logic                  w_s2_ovf;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_waddr;
  logic [CNT_WIDTH-1:0]  w_ram_wdata;
  logic [ADDR_WIDTH-1:0] w_ram_raddr;

  // A read always wins arbitration; a colliding increment is simply not accepted.
  assign w_rd_acc   = r_init_done & rd_en;
  assign w_inc_acc  = r_init_done & ~rd_en & inc_valid;
  assign w_acc_addr = w_rd_acc ? rd_addr : inc_addr;

  assign inc_ready  = r_init_done & ~rd_en;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign ovf        = r_ovf;
  assign init_done  = r_init_done;

  always_comb begin
    w_old     = r_fwd ? r_fwd_data : r_ram_q;
    w_sum     = {1'b0, w_old} + {{(CNT_WIDTH+1-INC_WIDTH){1'b0}}, r_s1_din};
    w_carry   = w_sum[CNT_WIDTH];
    w_inc_val = w_sum[CNT_WIDTH-1:0];
    if (w_carry && (SATURATE != 0)) begin
      w_inc_val = '1;
    end
    // Reads only write back when clearing; out-of-range ops never write.
    w_s2_we    = r_s1_valid & r_s1_inr & (~r_s1_rd | r_s1_clr);
    w_s2_wdata = r_s1_rd ? '0 : w_inc_val;
    w_s2_ovf   = r_s1_valid & r_s1_inr & ~r_s1_rd & w_carry;

    w_ram_we    = w_s2_we;
    w_ram_waddr = r_s1_addr;
    w_ram_wdata = w_s2_wdata;
    if (!r_init_done) begin
      w_ram_we    = (r_init_cnt != LP_N);
      w_ram_waddr = r_init_cnt[ADDR_WIDTH-1:0];
      w_ram_wdata = '0;
    end
    w_ram_raddr = r_s0_inr ? r_s0_addr : '0;
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_waddr] <= w_ram_wdata;
    end
    r_ram_q <= r_mem[w_ram_raddr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else if (!r_init_done) begin
      if (r_init_cnt == LP_N) begin
        r_init_done <= 1'b1;
      end else begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s0_valid <= 1'b0;
      r_s0_rd    <= 1'b0;
      r_s0_clr   <= 1'b0;
      r_s0_inr   <= 1'b0;
      r_s0_addr  <= '0;
      r_s0_din   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_rd    <= 1'b0;
      r_s1_clr   <= 1'b0;
      r_s1_inr   <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_din   <= '0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_s0_valid <= w_rd_acc | w_inc_acc;
      r_s0_rd    <= w_rd_acc;
      r_s0_clr   <= w_rd_acc & rd_clear;
      r_s0_addr  <= w_acc_addr;
      r_s0_din   <= w_inc_acc ? inc_din : '0;
      r_s0_inr   <= ({1'b0, w_acc_addr} < LP_N);

      r_s1_valid <= r_s0_valid;
      r_s1_rd    <= r_s0_rd;
      r_s1_clr   <= r_s0_clr;
      r_s1_inr   <= r_s0_inr;
      r_s1_addr  <= r_s0_addr;
      r_s1_din   <= r_s0_din;

      // The RAM returns pre-write data when read and written on the same edge.
      r_fwd      <= w_s2_we & r_s0_valid & (r_s0_addr == r_s1_addr);
      r_fwd_data <= w_s2_wdata;

      r_rd_valid <= r_s1_valid & r_s1_rd;
      if (r_s1_valid && r_s1_rd) begin
        r_rd_data <= r_s1_inr ? w_old : '0;
      end
      r_ovf <= w_s2_ovf;
    end
  end

endmodule

// File: tb/tb_statistics_counter_bank.sv
// Bench for statistics_counter_bank: a 1000-entry wrapping bank driven from a
// vector table with a read scoreboard, plus two 8-bit banks for wrap/saturate.
module tb_statistics_counter_bank;

  localparam int N_MAIN = 1000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        inc_valid = 1'b0, rd_en = 1'b0, rd_clear = 1'b0;
  logic [9:0]  inc_addr = '0, rd_addr = '0;
  logic [15:0] inc_din = '0;
  logic        inc_ready, rd_valid, ovf, init_done;
  logic [31:0] rd_data;

  logic        s_inc_valid = 1'b0, s_rd_en = 1'b0, s_rd_clear = 1'b0;
  logic [3:0]  s_inc_addr = '0, s_rd_addr = '0;
  logic [7:0]  s_inc_din = '0;
  logic        w8_inc_ready, w8_rd_valid, w8_ovf, w8_init_done;
  logic [7:0]  w8_rd_data;
  logic        s8_inc_ready, s8_rd_valid, s8_ovf, s8_init_done;
  logic [7:0]  s8_rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit ovf_main_seen = 1'b0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        rd;
    logic        clr;
    logic [9:0]  raddr;
    logic        inc;
    logic [9:0]  iaddr;
    logic [15:0] din;
    logic        exp_rdy;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tv[$];

  statistics_counter_bank #(
    .N_COUNTERS(N_MAIN), .ADDR_WIDTH(10), .CNT_WIDTH(32), .INC_WIDTH(16), .SATURATE(0)
  ) u_dut (
    .clk(clk), .resetn(resetn),
    .inc_valid(inc_valid), .inc_ready(inc_ready), .inc_addr(inc_addr), .inc_din(inc_din),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_clear(rd_clear),
    .rd_valid(rd_valid), .rd_data(rd_data), .ovf(ovf), .init_done(init_done)
  );

  statistics_counter_bank #(
    .N_COUNTERS(16), .ADDR_WIDTH(4), .CNT_WIDTH(8), .INC_WIDTH(8), .SATURATE(0)
  ) u_wrap8 (
    .clk(clk), .resetn(resetn),
    .inc_valid(s_inc_valid), .inc_ready(w8_inc_ready), .inc_addr(s_inc_addr), .inc_din(s_inc_din),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_clear(s_rd_clear),
    .rd_valid(w8_rd_valid), .rd_data(w8_rd_data), .ovf(w8_ovf), .init_done(w8_init_done)
  );

  statistics_counter_bank #(
    .N_COUNTERS(16), .ADDR_WIDTH(4), .CNT_WIDTH(8), .INC_WIDTH(8), .SATURATE(1)
  ) u_sat8 (
    .clk(clk), .resetn(resetn),
    .inc_valid(s_inc_valid), .inc_ready(s8_inc_ready), .inc_addr(s_inc_addr), .inc_din(s_inc_din),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_clear(s_rd_clear),
    .rd_valid(s8_rd_valid), .rd_data(s8_rd_data), .ovf(s8_ovf), .init_done(s8_init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard: every rd_valid must match the oldest pending read, on the right cycle.
  always @(negedge clk) begin
    if (ovf) ovf_main_seen = 1'b1;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("read  cyc=%0d data=%0d", cyc, rd_data);
        check("rd_data", rd_data, e.data);
        check("rd_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic vec_t mk(input bit rd, input bit clr, input int ra, input bit inc,
                              input int ia, input int din, input bit rdy, input int exp);
    vec_t v;
    v.rd = rd; v.clr = clr; v.raddr = 10'(ra); v.inc = inc; v.iaddr = 10'(ia);
    v.din = 16'(din); v.exp_rdy = rdy; v.exp_data = 32'(exp);
    return v;
  endfunction

  function automatic vec_t mk_rd(input int a, input bit clr, input int exp);
    return mk(1'b1, clr, a, 1'b0, 0, 0, 1'b0, exp);
  endfunction

  function automatic vec_t mk_inc(input int a, input int din);
    return mk(1'b0, 1'b0, 0, 1'b1, a, din, 1'b1, 0);
  endfunction

  task automatic apply(input vec_t v);
    rd_en = v.rd; rd_clear = v.clr; rd_addr = v.raddr;
    inc_valid = v.inc; inc_addr = v.iaddr; inc_din = v.din;
    #1;
    check("inc_ready", 32'(inc_ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    $display("issue cyc=%0d rd=%0b clr=%0b raddr=%0d inc=%0b iaddr=%0d din=%0d",
             cyc, v.rd, v.clr, v.raddr, v.inc, v.iaddr, v.din);
    if (v.rd) exp_q.push_back('{data: v.exp_data, cyc: cyc + 2});
    rd_en = 1'b0; rd_clear = 1'b0; inc_valid = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) seen = 1'b1;
    end
    check(name, 32'(n), 32'(N_MAIN + 1));
  endtask

  task automatic small_inc(input logic [7:0] din, input bit w_ovf, input bit s_ovf);
    s_inc_valid = 1'b1; s_inc_addr = 4'd3; s_inc_din = din;
    @(posedge clk);
    #1;
    s_inc_valid = 1'b0;
    $display("small inc addr=3 din=%0d", din);
    repeat (2) @(posedge clk);
    #1;
    check("wrap8_ovf", 32'(w8_ovf), 32'(w_ovf));
    check("sat8_ovf", 32'(s8_ovf), 32'(s_ovf));
  endtask

  task automatic small_read(input logic [7:0] w_exp, input logic [7:0] s_exp);
    s_rd_en = 1'b1; s_rd_addr = 4'd3;
    @(posedge clk);
    #1;
    s_rd_en = 1'b0;
    @(posedge clk);
    #1;
    check("wrap8_rd_valid_early", 32'(w8_rd_valid), 32'd0);
    @(posedge clk);
    #1;
    $display("small read addr=3 wrap=%0d sat=%0d", w8_rd_data, s8_rd_data);
    check("wrap8_rd_valid", 32'(w8_rd_valid), 32'd1);
    check("sat8_rd_valid", 32'(s8_rd_valid), 32'd1);
    check("wrap8_rd_data", 32'(w8_rd_data), 32'(w_exp));
    check("sat8_rd_data", 32'(s8_rd_data), 32'(s_exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reads of fresh counters, then back-to-back and alternating increments.
    for (int i = 0; i < 4; i++) tv.push_back(mk_rd(i, 1'b0, 0));
    for (int i = 0; i < 10; i++) tv.push_back(mk_inc(42, 1));
    tv.push_back(mk_rd(42, 1'b1, 10));
    for (int i = 0; i < 5; i++) begin
      tv.push_back(mk_inc(42, 1));
      tv.push_back(mk_inc(43, 1));
    end
    tv.push_back(mk_rd(42, 1'b0, 5));
    tv.push_back(mk_rd(43, 1'b0, 5));
    // Collision: the increment stalls and is re-presented next cycle.
    tv.push_back(mk(1'b1, 1'b0, 0, 1'b1, 9, 1, 1'b0, 0));
    tv.push_back(mk_inc(9, 1));
    tv.push_back(mk_rd(9, 1'b0, 1));
    // Read-and-clear followed immediately by an increment.
    tv.push_back(mk_inc(7, 100));
    tv.push_back(mk_rd(7, 1'b1, 100));
    tv.push_back(mk_inc(7, 3));
    tv.push_back(mk_rd(7, 1'b0, 3));
    // rd_clear without rd_en has no effect.
    tv.push_back(mk(1'b0, 1'b1, 7, 1'b1, 7, 2, 1'b1, 0));
    tv.push_back(mk_rd(7, 1'b0, 5));
    // Out-of-range increment and read; neighbour 999 untouched.
    tv.push_back(mk_inc(1010, 5));
    tv.push_back(mk_rd(1010, 1'b0, 0));
    tv.push_back(mk_rd(999, 1'b0, 0));
    // Distance-2 update and full-width increments.
    tv.push_back(mk_inc(500, 7));
    tv.push_back(mk(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 0));
    tv.push_back(mk_rd(500, 1'b0, 7));
    tv.push_back(mk_inc(600, 16'hFFFF));
    tv.push_back(mk_inc(600, 16'hFFFF));
    tv.push_back(mk_rd(600, 1'b0, 32'h1FFFE));

    repeat (3) @(posedge clk);
    #1;
    check("reset_init_done", 32'(init_done), 32'd0);
    check("reset_inc_ready", 32'(inc_ready), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    resetn = 1'b1;
    wait_init("init_sweep_cycles");

    foreach (tv[i]) apply(tv[i]);
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // 8-bit banks: wrap vs saturate on counter 3.
    small_inc(8'd250, 1'b0, 1'b0);
    small_inc(8'd10, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("wrap8_ovf_single_cycle", 32'(w8_ovf), 32'd0);
    small_read(8'd4, 8'd255);
    small_inc(8'd1, 1'b0, 1'b1);
    small_read(8'd5, 8'd255);
    small_inc(8'd0, 1'b0, 1'b0);
    small_read(8'd5, 8'd255);

    // Reset with a read in flight: the read must never return.
    apply(mk_inc(5, 1));
    apply(mk_inc(5, 1));
    apply(mk_rd(5, 1'b0, 2));
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("midop_reset_init_done", 32'(init_done), 32'd0);
    check("midop_reset_inc_ready", 32'(inc_ready), 32'd0);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("flushed_rd_valid", 32'(rd_valid), 32'd0);
    end
    repeat (100) @(posedge clk);
    #1;
    check("mid_sweep_init_done", 32'(init_done), 32'd0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_init("resweep_cycles");
    apply(mk_rd(5, 1'b0, 0));
    apply(mk_rd(42, 1'b0, 0));
    apply(mk_rd(7, 1'b0, 0));
    apply(mk_rd(600, 1'b0, 0));
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained_after_reset", 32'(exp_q.size()), 32'd0);
    check("main_ovf_never", 32'(ovf_main_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
